// File: rtl/gate_truth_checker.sv
// Built-in self-test sequencer: sweeps all four {a,b} vectors into a 2-input gate
// and records which vectors disagree with the expected truth table.
module gate_truth_checker #(
    parameter logic [3:0]  EXPECTED = 4'b0111,
    parameter int unsigned SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       mismatch;
    logic [2:0] err_next;

    // err_next already includes the current vector, so the final pass flag sees it
    assign mismatch = (gate_out != EXPECTED[idx]);
    assign err_next = err_count + {2'b00, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        idx       <= 2'd0;
                        cnt       <= 4'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    if (idx != 2'd3) begin
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                        cnt    <= 4'd0;
                        state  <= ST_SETTLE;
                    end else begin
                        state <= ST_DONE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a behavioural gate feeds each checker, and the
// expected sweep verdicts go through a scoreboard queue.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic       a1, b1, gate1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    logic       a3, b3, gate3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [3:0] fv3;
    int         mode1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    gate_truth_checker #(.EXPECTED(4'b0111), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_out(gate1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
    );

    gate_truth_checker #(.EXPECTED(4'b0111), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .gate_out(gate3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3)
    );

    // Gate under test: 0 = NAND, 1 = stuck at 1, 2 = stuck at 0, 3 = AND
    function automatic logic gate_ref(input int mode, input logic va, input logic vb);
        case (mode)
            0:       return ~(va & vb);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return va & vb;
        endcase
    endfunction

    always_comb gate1 = gate_ref(mode1, a1, b1);
    assign gate3 = ~(a3 & b3);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected verdict packed as {pass, err_count, fail_vec}
    task automatic push_expected(input int mode);
        logic [3:0] fv;
        logic [2:0] ec;
        logic [1:0] v;
        fv = 4'd0;
        ec = 3'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (gate_ref(mode, v[1], v[0]) != ~(v[1] & v[0])) begin
                fv[i] = 1'b1;
                ec    = ec + 3'd1;
            end
        end
        sb_q.push_back({(ec == 3'd0), ec, fv});
    endtask

    task automatic pop_compare(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check(tag, 16'(obs), 16'(exp));
        end else begin
            check({tag, "_sb_empty"}, 16'd1, 16'd0);
        end
    endtask

    // Launch one sweep on dut1; returns at the negedge right after the accepting edge
    task automatic apply_stimulus(input int mode);
        mode1 = mode;
        push_expected(mode);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Follow a SETTLE=1 sweep: vector n/2 visible on even cycles, done at cycle 8
    task automatic check_output(input string name);
        int done_at;
        done_at = -1;
        for (int n = 0; n < 40 && done_at < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (done1) begin
                done_at = n;
            end else if (n < 8 && n % 2 == 0) begin
                check({name, "_vec"}, 16'({busy1, a1, b1}), 16'({1'b1, 2'(n / 2)}));
            end
        end
        check({name, "_done_cycle"}, 16'(done_at), 16'd8);
        check({name, "_done_busy_ab"}, 16'({busy1, a1, b1}), 16'd0);
        pop_compare({name, "_result"}, {pass1, err1, fv1});
        @(negedge clk);
        check({name, "_done_pulse"}, 16'(done1), 16'd0);
    endtask

    initial begin
        int done_at;
        int saw_done;
        rst_n  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = 0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_dut1", 16'({a1, b1, busy1, done1, pass1, err1, fv1}), 16'd0);
        check("reset_dut3", 16'({a3, b3, busy3, done3, pass3, err3, fv3}), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(0);
        check_output("nand");
        apply_stimulus(1);
        check_output("stuck1");
        apply_stimulus(2);
        check_output("stuck0");
        apply_stimulus(3);
        check_output("and");

        // Idle without start: verdict must hold
        repeat (3) @(negedge clk);
        check("hold_after_done", 16'({busy1, pass1, err1, fv1}), 16'({1'b0, 1'b0, 3'd4, 4'hf}));

        // Reset during vector 2 aborts the sweep asynchronously
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_vec2", 16'({busy1, a1, b1}), 16'b110);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async", 16'({a1, b1, busy1, done1, pass1, err1, fv1}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done1) saw_done = 1;
        end
        check("abort_no_done", 16'(saw_done), 16'd0);
        apply_stimulus(0);
        check_output("after_abort");

        // SETTLE=3 with start held high: one sweep, restart on first IDLE edge
        push_expected(0);
        push_expected(0);
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_at = -1;
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (done3) done_at = n;
        end
        check("s3_done_cycle", 16'(done_at), 16'd16);
        pop_compare("s3_result", {pass3, err3, fv3});
        @(negedge clk);
        check("s3_idle", 16'({busy3, done3}), 16'd0);
        @(negedge clk);
        check("s3_restart", 16'({busy3, a3, b3}), 16'b100);
        start3 = 1'b0;
        done_at = -1;
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (done3) done_at = n;
        end
        check("s3_second_done", 16'(done_at), 16'd16);
        pop_compare("s3_second_result", {pass3, err3, fv3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 The module SHALL have parameter EXPECTED, default 4'b0111, giving the expected gate output for each vector, indexed by {a,b} (NAND truth table).
REQ-002 The module SHALL have parameter SETTLE, default 1, range 1..15, giving the settle cycles between driving a vector and sampling it.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  request to run one truth-table sweep; sampled only in IDLE.
REQ-006 The module SHALL have port a  output  1  registered stimulus, MSB of the vector index, driven to the gate under test.
REQ-007 The module SHALL have port b  output  1  registered stimulus, LSB of the vector index, driven to the gate under test.
REQ-008 The module SHALL have port gate_out  input  1  output of the gate under test.
REQ-009 The module SHALL have port busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE state).
REQ-010 The module SHALL have port done  output  1  one-cycle pulse marking the end of a sweep.
REQ-011 The module SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 The module SHALL have port err_count  output  3  number of mismatching vectors in the current or last sweep (0..4).
REQ-013 The module SHALL have port fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE, start=1 at rising edge k SHALL:
- set idx=0, a=0, b=0;
- clear err_count, fail_vec and pass;
- clear the settle counter;
- enter SETTLE.
REQ-016 In IDLE, start=0 SHALL leave all outputs unchanged.
REQ-017 SETTLE SHALL last exactly SETTLE cycles, incrementing the counter each edge and entering SAMPLE on the edge where the counter equals SETTLE-1.
REQ-018 On the SAMPLE edge, gate_out SHALL be compared with EXPECTED[idx].
REQ-019 On mismatch, the SAMPLE edge SHALL set fail_vec[idx] and increment err_count by 1.
REQ-020 On the SAMPLE edge, if idx<3, the module SHALL increment idx, drive {a,b}=idx+1, clear the counter and enter SETTLE.
REQ-021 On the SAMPLE edge, if idx==3, the module SHALL:
- enter DONE;
- set a=0 and b=0;
- load pass with (final err_count==0), including any update made on this edge.
REQ-022 Timing SHALL be: vector i driven at edge k+i(SETTLE+1); gate_out for vector i sampled at edge k+(i+1)(SETTLE+1); DONE entered at edge k+4(SETTLE+1).
REQ-023 done SHALL be high only for the single cycle spent in DONE.
REQ-024 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-025 start asserted in SETTLE, SAMPLE or DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-027 pass, err_count and fail_vec SHALL hold their values from DONE until the next accepted start.
REQ-028 err_count SHALL saturate naturally at 4 (at most 4 vectors) and SHALL never wrap.
REQ-029 a, b, busy, done, pass, err_count and fail_vec SHALL all be driven directly from flip-flops.

Reset
REQ-030 rst_n=0 SHALL force, immediately and independent of clk:
- state=IDLE, idx=0, counter=0;
- a=0, b=0;
- busy=0, done=0, pass=0;
- err_count=0, fail_vec=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-032 After rst_n deasserts, the first start accepted in IDLE SHALL begin a fresh sweep.

Verification
REQ-033 Correct NAND model, SETTLE=1, start pulse at edge k -> {a,b} = 00,01,10,11 at edges k, k+2, k+4, k+6; done=1 for one cycle after edge k+8; pass=1; err_count=0; fail_vec=0000.
REQ-034 gate_out stuck at 1 -> pass=0, err_count=1, fail_vec=1000.
REQ-035 gate_out stuck at 0 -> pass=0, err_count=3, fail_vec=0111.
REQ-036 gate_out = a AND b (inverted NAND) -> pass=0, err_count=4, fail_vec=1111.
REQ-037 start held high throughout a sweep, SETTLE=3 -> exactly one sweep runs; done occurs 16 cycles after acceptance; a new sweep starts on the first IDLE edge after done.
REQ-038 rst_n pulsed low during vector 2 -> all outputs return to reset values asynchronously and no done pulse occurs; a following start completes a normal sweep with pass=1.
